climate_sample_driver: RTL and testbench
========================================

CLIMATE_SAMPLE_DRIVER -- requirements
Module: climate_sample_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16; maximum cycles to wait for predictor done.
REQ-002 SHALL have parameter CNT_W, default 16; width of per-class statistics counters.
REQ-003 SHALL have ports clk (in, 1, sole clock) and rst (in, 1, synchronous active-high reset).
REQ-004 SHALL have sensor side: s_valid (in, 1), s_ready (out, 1), s_temperature (in, 32, signed), s_pressure (in, 32, unsigned).
REQ-005 SHALL have predictor side: temperature (out, 32, signed), pressure (out, 32), snow, sunny, storm, error, done (in, 1 each).
REQ-006 SHALL have result side: r_valid (out, 1), r_ready (in, 1), r_class (out, 2: 00 snow, 01 sunny, 10 storm, 11 error), r_timeout (out, 1).
REQ-007 SHALL have statistics outputs cnt_snow, cnt_sunny, cnt_storm, cnt_error (out, CNT_W each) and protocol_err (out, 1).

Function
REQ-008 SHALL implement FSM states IDLE, DRIVE, RESULT; transitions only on rising clk.
REQ-009 IDLE: s_ready=1; on s_valid&&s_ready SHALL latch s_temperature/s_pressure into drive registers and go to DRIVE.
REQ-010 temperature/pressure outputs SHALL equal drive registers at all times and change only on accepted sensor handshake.
REQ-011 DRIVE: s_ready=0; SHALL run wait counter starting at 0 on entry, incrementing each cycle.
REQ-012 done SHALL be ignored while wait counter < 2 (discard verdict computed on the stale sample); first done with counter >= 2 captures class and moves to RESULT.
REQ-013 Class capture without the REQ-023 feature SHALL be priority snow > sunny > storm > error; no flag set -> error.
REQ-014 If wait counter reaches TIMEOUT_CYCLES without accepted done, SHALL move to RESULT with r_class=11, r_timeout=1.
REQ-015 done and timeout in the same cycle: done SHALL win, r_timeout=0.
REQ-016 RESULT: r_valid=1; r_class and r_timeout SHALL stay stable until r_valid&&r_ready, then return to IDLE.
REQ-017 s_ready SHALL be 0 in RESULT; a new sample is accepted no earlier than the cycle after the result handshake.
REQ-018 On result handshake the counter matching r_class SHALL increment by 1, saturating at 2^CNT_W-1; timeouts count in cnt_error.
REQ-019 r_valid, s_ready SHALL be registered-state-decoded (no combinational path from r_ready or s_valid).

Reset
REQ-020 rst=1 at a clock edge SHALL force IDLE, s_ready=1 on the following cycle, r_valid=0, r_class=00, r_timeout=0, all counters 0, protocol_err=0.
REQ-021 rst SHALL clear drive registers so temperature=0, pressure=0.
REQ-022 rst asserted in DRIVE or RESULT SHALL abandon the transaction; no counter update, no r_valid pulse.

Configuration
REQ-023 Macro CLIMATE_DRV_ONEHOT_CHECK_EN defined: accepted done SHALL require exactly one of snow/sunny/storm/error set; otherwise r_class=11 and sticky protocol_err=1 until rst.
REQ-024 Macro undefined: REQ-013 priority encoding SHALL apply and protocol_err SHALL be tied 0.

Verification
REQ-025 Reset, then s_temperature=-5, s_pressure=1000, s_valid=1; done+snow at DRIVE cycle 2 -> r_valid=1, r_class=00, cnt_snow=1 after r_ready.
REQ-026 Sample 30/1100; done+error at DRIVE cycle 0, done+sunny at cycle 2 -> stale done ignored, r_class=01, cnt_sunny=1.
REQ-027 Sample 60/800, done never asserted, TIMEOUT_CYCLES=16 -> RESULT after 16 DRIVE cycles, r_class=11, r_timeout=1, cnt_error=1.
REQ-028 r_ready held 0 for 10 cycles in RESULT with s_valid=1 -> r_class stable, s_ready=0, no new sample latched, temperature unchanged.
REQ-029 With CLIMATE_DRV_ONEHOT_CHECK_EN: done with snow=1, storm=1 -> r_class=11, protocol_err=1 persisting until rst; without macro -> r_class=00, protocol_err=0.
REQ-030 rst=1 mid-DRIVE, CNT_W=2 counters pre-saturated at 3 -> all outputs reset values, no r_valid; separately, a 4th snow result with cnt_snow=3 keeps cnt_snow=3.

Source files
------------

// File: rtl/climate_sample_driver_if.sv
// climate_sample_driver_if: sensor, predictor and result handshake bundle
interface climate_sample_driver_if;
    logic               s_valid;
    logic               s_ready;
    logic signed [31:0] s_temperature;
    logic        [31:0] s_pressure;
    logic signed [31:0] temperature;
    logic        [31:0] pressure;
    logic               snow;
    logic               sunny;
    logic               storm;
    logic               error;
    logic               done;
    logic               r_valid;
    logic               r_ready;
    logic        [1:0]  r_class;
    logic               r_timeout;
    modport master (
        input  s_valid, s_temperature, s_pressure, snow, sunny, storm, error, done, r_ready,
        output s_ready, temperature, pressure, r_valid, r_class, r_timeout
    );
    modport slave (
        output s_valid, s_temperature, s_pressure, snow, sunny, storm, error, done, r_ready,
        input  s_ready, temperature, pressure, r_valid, r_class, r_timeout
    );
endinterface

// File: rtl/climate_sample_driver.sv
// climate_sample_driver: holds one sensor sample on the predictor, captures its verdict (or a timeout) and keeps per-class statistics; CLIMATE_DRV_ONEHOT_CHECK_EN enables one-hot verdict checking
module climate_sample_driver #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    climate_sample_driver_if.master bus,
    output logic [CNT_W-1:0]       cnt_snow,
    output logic [CNT_W-1:0]       cnt_sunny,
    output logic [CNT_W-1:0]       cnt_storm,
    output logic [CNT_W-1:0]       cnt_error,
    output logic                   protocol_err
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [1:0] {IDLE, DRIVE, RESULT} state_t;
    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [31:0]      temp_q, temp_d;
    logic [31:0]      pres_q, pres_d;
    logic [1:0]       class_q, class_d;
    logic             timeout_q, timeout_d;
    logic             perr_q, perr_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [1:0]       verdict;
    logic             bad_verdict;

    // Map predictor flags onto a class code; a malformed flag set becomes error when checking is enabled
    always_comb begin
        verdict = bus.snow ? 2'd0 : bus.sunny ? 2'd1 : bus.storm ? 2'd2 : 2'd3;
`ifdef CLIMATE_DRV_ONEHOT_CHECK_EN
        bad_verdict = !$onehot({bus.snow, bus.sunny, bus.storm, bus.error});
        verdict = bad_verdict ? 2'd3 : verdict;
`else
        bad_verdict = 1'b0;
`endif
    end

    // Next state: accept sample, wait for a fresh verdict or timeout, then hand out the result and count it
    always_comb begin
        state_d = state_q;
        wait_d = wait_q;
        temp_d = temp_q;
        pres_d = pres_q;
        class_d = class_q;
        timeout_d = timeout_q;
        perr_d = perr_q;
        cnt_d = cnt_q;
        if (state_q == IDLE) begin
            if (bus.s_valid) begin
                state_d = DRIVE;
                wait_d = '0;
                temp_d = bus.s_temperature;
                pres_d = bus.s_pressure;
            end
        end else if (state_q == DRIVE) begin
            wait_d = wait_q + 1'b1;
            if (bus.done && wait_q >= WW'(2)) begin
                state_d = RESULT;
                class_d = verdict;
                timeout_d = 1'b0;
                perr_d = perr_q | bad_verdict;
            end else if (wait_q == WW'(TIMEOUT_CYCLES - 1)) begin
                state_d = RESULT;
                class_d = 2'd3;
                timeout_d = 1'b1;
            end
        end else if (bus.r_ready) begin
            state_d = IDLE;
            if (cnt_q[class_q] != '1) cnt_d[class_q] = cnt_q[class_q] + 1'b1;
        end
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wait_q <= '0;
            temp_q <= '0;
            pres_q <= '0;
            class_q <= 2'd0;
            timeout_q <= 1'b0;
            perr_q <= 1'b0;
            cnt_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            wait_q <= wait_d;
            temp_q <= temp_d;
            pres_q <= pres_d;
            class_q <= class_d;
            timeout_q <= timeout_d;
            perr_q <= perr_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.s_ready = state_q == IDLE;
    assign bus.r_valid = state_q == RESULT;
    assign bus.temperature = temp_q;
    assign bus.pressure = pres_q;
    assign bus.r_class = class_q;
    assign bus.r_timeout = timeout_q;
    assign cnt_snow = cnt_q[0];
    assign cnt_sunny = cnt_q[1];
    assign cnt_storm = cnt_q[2];
    assign cnt_error = cnt_q[3];
    assign protocol_err = perr_q;
endmodule

// File: tb/tb_climate_sample_driver.sv
// tb_climate_sample_driver: directed and random stimulus checked every cycle against a transaction-level model
module tb_climate_sample_driver;
    localparam int T = 16;
    localparam int CW = 2;
    localparam int MAXC = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst;
    logic [CW-1:0] cnt_snow, cnt_sunny, cnt_storm, cnt_error;
    logic protocol_err;
    int checks = 0;
    int passes = 0;
    bit mdl_on = 1'b0;

    climate_sample_driver_if bus ();

    climate_sample_driver #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cnt_snow(cnt_snow), .cnt_sunny(cnt_sunny), .cnt_storm(cnt_storm), .cnt_error(cnt_error),
        .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Transaction-level model: a held sample ages each cycle; a verdict older than two cycles or the age limit produces a result
    logic [31:0] m_temp, m_pres;
    logic [1:0]  m_class;
    bit          m_busy, m_res, m_to, m_perr;
    int          m_age;
    int          m_cnt [4];

    always @(posedge clk) begin
        int n;
        if (rst) begin
            m_temp = 0;
            m_pres = 0;
            m_class = 0;
            m_busy = 0;
            m_res = 0;
            m_to = 0;
            m_perr = 0;
            m_age = 0;
            m_cnt = '{default: 0};
        end else if (m_res) begin
            if (bus.r_ready) begin
                m_cnt[m_class] = (m_cnt[m_class] < MAXC) ? m_cnt[m_class] + 1 : MAXC;
                m_res = 0;
            end
        end else if (m_busy) begin
            if (bus.done && m_age >= 2) begin
                n = int'(bus.snow) + int'(bus.sunny) + int'(bus.storm) + int'(bus.error);
                m_class = bus.snow ? 2'd0 : bus.sunny ? 2'd1 : bus.storm ? 2'd2 : 2'd3;
`ifdef CLIMATE_DRV_ONEHOT_CHECK_EN
                if (n != 1) begin
                    m_class = 2'd3;
                    m_perr = 1;
                end
`endif
                m_to = 0;
                m_busy = 0;
                m_res = 1;
            end else if (m_age == T - 1) begin
                m_class = 2'd3;
                m_to = 1;
                m_busy = 0;
                m_res = 1;
            end else begin
                m_age++;
            end
        end else if (bus.s_valid) begin
            m_temp = bus.s_temperature;
            m_pres = bus.s_pressure;
            m_busy = 1;
            m_age = 0;
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("s_ready", bus.s_ready, !(m_busy || m_res));
            chk("r_valid", bus.r_valid, m_res);
            chk("temperature", bus.temperature, m_temp);
            chk("pressure", bus.pressure, m_pres);
            chk("cnt_snow", cnt_snow, m_cnt[0]);
            chk("cnt_sunny", cnt_sunny, m_cnt[1]);
            chk("cnt_storm", cnt_storm, m_cnt[2]);
            chk("cnt_error", cnt_error, m_cnt[3]);
            chk("protocol_err", protocol_err, m_perr);
            if (m_res) begin
                chk("r_class", bus.r_class, m_class);
                chk("r_timeout", bus.r_timeout, m_to);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input bit d, input logic [3:0] f);
        bus.done = d;
        {bus.snow, bus.sunny, bus.storm, bus.error} = f;
    endtask

    task automatic send(input logic [31:0] t, input logic [31:0] p);
        bus.s_valid = 1;
        bus.s_temperature = t;
        bus.s_pressure = p;
        tick();
        bus.s_valid = 0;
    endtask

    task automatic verdict2(input logic [3:0] f);
        tick();
        tick();
        set_flags(1, f);
        tick();
        set_flags(0, 4'b0);
    endtask

    task automatic ack();
        bus.r_ready = 1;
        tick();
        bus.r_ready = 0;
    endtask

    task automatic run_one(input logic [3:0] f);
        send(32'd5, 32'd6);
        verdict2(f);
        ack();
    endtask

    initial begin
        int dprob;
        rst = 1;
        bus.s_valid = 0;
        bus.s_temperature = 0;
        bus.s_pressure = 0;
        set_flags(0, 4'b0);
        bus.r_ready = 0;
        tick();
        tick();
        mdl_on = 1;
        rst = 0;
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_r_class", bus.r_class, 0);
        chk("rst_r_timeout", bus.r_timeout, 0);
        chk("rst_temperature", bus.temperature, 0);
        chk("rst_cnt_snow", cnt_snow, 0);
        // snow verdict at wait cycle 2
        send(32'(-5), 32'd1000);
        chk("drv_temp", bus.temperature, 32'hFFFF_FFFB);
        chk("drv_pres", bus.pressure, 32'd1000);
        chk("drv_s_ready", bus.s_ready, 0);
        verdict2(4'b1000);
        chk("snow_r_valid", bus.r_valid, 1);
        chk("snow_r_class", bus.r_class, 0);
        chk("snow_r_timeout", bus.r_timeout, 0);
        ack();
        chk("snow_cnt", cnt_snow, 1);
        chk("snow_s_ready", bus.s_ready, 1);
        // stale error verdict at cycle 0 ignored, sunny at cycle 2 taken
        send(32'd30, 32'd1100);
        set_flags(1, 4'b0001);
        tick();
        set_flags(0, 4'b0);
        tick();
        set_flags(1, 4'b0100);
        tick();
        set_flags(0, 4'b0);
        chk("sunny_r_valid", bus.r_valid, 1);
        chk("sunny_r_class", bus.r_class, 1);
        ack();
        chk("sunny_cnt", cnt_sunny, 1);
        chk("sunny_cnt_error", cnt_error, 0);
        // timeout after exactly T drive cycles
        send(32'd60, 32'd800);
        repeat (T - 1) tick();
        chk("to_early_r_valid", bus.r_valid, 0);
        tick();
        chk("to_r_valid", bus.r_valid, 1);
        chk("to_r_class", bus.r_class, 3);
        chk("to_r_timeout", bus.r_timeout, 1);
        // result held with back-pressure while a new sample waits
        bus.s_valid = 1;
        bus.s_temperature = 32'd99;
        repeat (10) begin
            tick();
            chk("hold_s_ready", bus.s_ready, 0);
            chk("hold_r_class", bus.r_class, 3);
            chk("hold_temp", bus.temperature, 32'd60);
        end
        bus.s_valid = 0;
        ack();
        chk("to_cnt_error", cnt_error, 1);
        chk("to_temp_kept", bus.temperature, 32'd60);
        // two flags at once
        send(32'd1, 32'd2);
        verdict2(4'b1010);
`ifdef CLIMATE_DRV_ONEHOT_CHECK_EN
        chk("multi_r_class", bus.r_class, 3);
        chk("multi_perr", protocol_err, 1);
`else
        chk("multi_r_class", bus.r_class, 0);
        chk("multi_perr", protocol_err, 0);
`endif
        ack();
        run_one(4'b1000);
`ifdef CLIMATE_DRV_ONEHOT_CHECK_EN
        chk("perr_sticky", protocol_err, 1);
`else
        chk("perr_sticky", protocol_err, 0);
`endif
        // saturate every counter
        repeat (4) run_one(4'b1000);
        chk("sat_snow", cnt_snow, 3);
        repeat (3) run_one(4'b0100);
        repeat (3) run_one(4'b0010);
        repeat (3) run_one(4'b0001);
        chk("sat_sunny", cnt_sunny, 3);
        chk("sat_storm", cnt_storm, 3);
        chk("sat_error", cnt_error, 3);
        // reset mid-drive abandons the sample
        send(32'd7, 32'd8);
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk("mid_rst_s_ready", bus.s_ready, 1);
        chk("mid_rst_r_valid", bus.r_valid, 0);
        chk("mid_rst_temp", bus.temperature, 0);
        chk("mid_rst_pres", bus.pressure, 0);
        chk("mid_rst_cnt_snow", cnt_snow, 0);
        chk("mid_rst_cnt_error", cnt_error, 0);
        chk("mid_rst_perr", protocol_err, 0);
        repeat (5) begin
            tick();
            chk("mid_rst_no_result", bus.r_valid, 0);
        end
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            dprob = (i < 1500) ? 25 : 3;
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_temperature = $urandom;
            bus.s_pressure = $urandom;
            set_flags($urandom_range(0, 99) < dprob, 4'($urandom_range(0, 15)));
            bus.r_ready = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end
        rst = 0;
        bus.s_valid = 0;
        set_flags(0, 4'b0);
        tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
